serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Parametrised multi-cycle N-bit subtractor that computes D = Ain − Bin − Bin_in a digit at a time, rippling the borrow between cycles through a registered borrow. It is the sequential, width-generic successor of the single-bit full subtractor cell. It trades latency for area and sits behind valid/ready handshakes so it can be dropped between a producer and a consumer in the datapath. Reports borrow-out, signed overflow and zero flags with each result.

## Interface
- WIDTH, 8: operand/result width in bits; ≥ 2.
- DIGIT, 1: bits processed per cycle; WIDTH % DIGIT must be 0 (elaboration error otherwise). STEPS = WIDTH/DIGIT.

Reset is synchronous and active-high on `rst`, sampled on the rising edge of `clk`; single clock domain.
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- Ain  in  WIDTH  minuend, unsigned or two's complement.
- Bin  in  WIDTH  subtrahend.
- Bin_in  in  1  borrow-in for the LSB digit.
- out_valid  out  1  result valid, held until accepted.
- out_ready  in  1  consumer accepts result.
- D  out  WIDTH  difference.
- Bout  out  1  borrow out of MSB (1 = unsigned Ain < Bin + Bin_in).
- OV  out  1  signed overflow.
- Z  out  1  D == 0.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: `in_ready` = 1. When `in_valid` && `in_ready`, latch Ain, Bin, Bin_in into internal shift registers, clear the step counter, and go to RUN.
- RUN: each cycle, take the low DIGIT bits of A and B and the registered borrow. Compute {borrow', d} = a − b − borrow, DIGIT+1 bits wide. Shift d into the result shift register from the MSB end, shift A and B right by DIGIT, and increment the counter.
- After the STEPS-th RUN cycle, go to DONE. On that same edge, load D, Bout, OV and Z:
  - Bout = final borrow.
  - OV = (Ain[MSB] ≠ Bin[MSB]) && (D[MSB] ≠ Ain[MSB]), using the latched operands.
  - Z = (D == 0).
- DONE: `out_valid` = 1. When `out_ready` = 1, go to IDLE. The result handshake completes on that edge. There is no same-cycle bypass to a new accept.
- `in_ready` = 1 only in IDLE and while `rst` = 0. `in_valid` is ignored in RUN and DONE.
- D, Bout, OV and Z change only on the completion edge. They hold the last result through IDLE and RUN of the next operation.
- `out_ready` outside DONE has no effect.
- Arithmetic is modulo 2^WIDTH, and Bin_in is included in the first digit.

## Timing
- Reset values: state = IDLE; D = 0, Bout = 0, OV = 0, Z = 0, out_valid = 0; internal registers and counter = 0. `in_ready` = 0 during the reset cycle and 1 in the first cycle after reset.
- Latency: accept on edge k, result registered on edge k+STEPS, so `out_valid` is high in the cycle after edge k+STEPS.
- Throughput: at most one operation per STEPS+2 cycles (accept, STEPS RUN cycles, one DONE cycle minimum).
- Backpressure: while `out_ready` = 0 in DONE, `out_valid` and all result outputs stay stable indefinitely.
- Reset mid-operation (RUN or DONE):
  - The operation is abandoned and no `out_valid` is produced.
  - All outputs take their reset values on that edge.
- Counter wrap: the counter compares against STEPS−1. It never counts past it or wraps in RUN.

## Test plan
- WIDTH=8, DIGIT=1: Ain=0x05, Bin=0x03, Bin_in=0 → D=0x02, Bout=0, OV=0, Z=0. `out_valid` rises exactly 8 cycles after the accept edge.
- WIDTH=8, DIGIT=1: 0x03 − 0x05 → D=0xFE, Bout=1, OV=0. 0x80 − 0x01 → D=0x7F, Bout=0, OV=1.
- WIDTH=8, DIGIT=1: 0x00 − 0x00 with Bin_in=1 → D=0xFF, Bout=1, Z=0. 0x10 − 0x10 with Bin_in=0 → D=0x00, Z=1.
- WIDTH=8, DIGIT=4: 0xA7 − 0x3C → D=0x6B, Bout=0, OV=1, latency 2 cycles. WIDTH=16, DIGIT=2: 0x1234 − 0x4321 → D=0xCF13, Bout=1.
- Handshake:
  - Hold `out_ready`=0 for 3 cycles in DONE → `out_valid` and D stable throughout. Raise it → IDLE next cycle.
  - `in_valid` pulses during RUN → ignored; the result matches the originally accepted operands.
- Assert `rst` for one cycle at RUN step 3 → no `out_valid`, outputs zero, `in_ready`=1 the next cycle. A fresh 0x09 − 0x04 then yields D=0x05.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// Valid/ready operand and result channels for the serial subtractor.
// The master side produces operands and consumes results; the slave side is the subtractor.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] Ain;
    logic [WIDTH-1:0] Bin;
    logic             Bin_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] D;
    logic             Bout;
    logic             OV;
    logic             Z;

    modport master (
        output in_valid, Ain, Bin, Bin_in, out_ready,
        input  in_ready, out_valid, D, Bout, OV, Z
    );

    modport slave (
        input  in_valid, Ain, Bin, Bin_in, out_ready,
        output in_ready, out_valid, D, Bout, OV, Z
    );
endinterface

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: D = Ain - Bin - Bin_in, DIGIT bits per cycle with a registered borrow.
// Results (D, Bout, OV, Z) are held from one completion edge until the next.
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input logic               clk,
    input logic               rst,
    serial_subtractor_if.slave bus
);
    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("serial_subtractor: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] res_next;
    logic [CW-1:0]    cnt;
    logic             borrow;
    logic             a_msb;
    logic             b_msb;
    logic [DIGIT:0]   diff;
    logic [WIDTH-1:0] d_q;
    logic             bout_q;
    logic             ov_q;
    logic             z_q;
    logic             valid_q;

    // One digit of a - b - borrow; the extra top bit is the outgoing borrow.
    assign diff = {1'b0, a_sh[DIGIT-1:0]} - {1'b0, b_sh[DIGIT-1:0]} - {{DIGIT{1'b0}}, borrow};

    // New digit enters at the MSB end so after STEPS shifts the LSB digit sits at bit 0.
    assign res_next = WIDTH'({diff[DIGIT-1:0], res_sh} >> DIGIT);

    assign bus.in_ready  = (state == IDLE) && !rst;
    assign bus.out_valid = valid_q;
    assign bus.D         = d_q;
    assign bus.Bout      = bout_q;
    assign bus.OV        = ov_q;
    assign bus.Z         = z_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            res_sh  <= '0;
            cnt     <= '0;
            borrow  <= 1'b0;
            a_msb   <= 1'b0;
            b_msb   <= 1'b0;
            d_q     <= '0;
            bout_q  <= 1'b0;
            ov_q    <= 1'b0;
            z_q     <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sh   <= bus.Ain;
                        b_sh   <= bus.Bin;
                        borrow <= bus.Bin_in;
                        a_msb  <= bus.Ain[WIDTH-1];
                        b_msb  <= bus.Bin[WIDTH-1];
                        res_sh <= '0;
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> DIGIT;
                    b_sh   <= b_sh >> DIGIT;
                    borrow <= diff[DIGIT];
                    res_sh <= res_next;
                    // Counter stops at LAST; the final digit publishes the result directly.
                    if (cnt == LAST) begin
                        state   <= DONE;
                        valid_q <= 1'b1;
                        d_q     <= res_next;
                        bout_q  <= diff[DIGIT];
                        ov_q    <= (a_msb != b_msb) && (res_next[WIDTH-1] != a_msb);
                        z_q     <= (res_next == '0);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        valid_q <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: three instances (8/1, 8/4, 16/2) share one
// stimulus path selected by 'sel'; expected values are hand-computed constants.
module tb_serial_subtractor;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  sel;
    logic [15:0] tbA;
    logic [15:0] tbB;
    logic        tbBinIn;
    logic        tbInValid;
    logic        tbOutReady;

    logic [15:0] obsD;
    logic        obsBout, obsOV, obsZ, obsOutValid, obsInReady;

    int total = 0;
    int bad   = 0;
    int lat;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(8))  bus0 ();
    serial_subtractor_if #(.WIDTH(8))  bus1 ();
    serial_subtractor_if #(.WIDTH(16)) bus2 ();

    assign bus0.in_valid  = tbInValid && (sel == 2'd0);
    assign bus0.Ain       = tbA[7:0];
    assign bus0.Bin       = tbB[7:0];
    assign bus0.Bin_in    = tbBinIn;
    assign bus0.out_ready = tbOutReady && (sel == 2'd0);

    assign bus1.in_valid  = tbInValid && (sel == 2'd1);
    assign bus1.Ain       = tbA[7:0];
    assign bus1.Bin       = tbB[7:0];
    assign bus1.Bin_in    = tbBinIn;
    assign bus1.out_ready = tbOutReady && (sel == 2'd1);

    assign bus2.in_valid  = tbInValid && (sel == 2'd2);
    assign bus2.Ain       = tbA;
    assign bus2.Bin       = tbB;
    assign bus2.Bin_in    = tbBinIn;
    assign bus2.out_ready = tbOutReady && (sel == 2'd2);

    serial_subtractor #(.WIDTH(8), .DIGIT(1))  dut0 (.clk(clk), .rst(rst), .bus(bus0));
    serial_subtractor #(.WIDTH(8), .DIGIT(4))  dut1 (.clk(clk), .rst(rst), .bus(bus1));
    serial_subtractor #(.WIDTH(16), .DIGIT(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    always_comb begin
        obsD        = '0;
        obsBout     = 1'b0;
        obsOV       = 1'b0;
        obsZ        = 1'b0;
        obsOutValid = 1'b0;
        obsInReady  = 1'b0;
        case (sel)
            2'd0: begin
                obsD = {8'h00, bus0.D}; obsBout = bus0.Bout; obsOV = bus0.OV; obsZ = bus0.Z;
                obsOutValid = bus0.out_valid; obsInReady = bus0.in_ready;
            end
            2'd1: begin
                obsD = {8'h00, bus1.D}; obsBout = bus1.Bout; obsOV = bus1.OV; obsZ = bus1.Z;
                obsOutValid = bus1.out_valid; obsInReady = bus1.in_ready;
            end
            2'd2: begin
                obsD = bus2.D; obsBout = bus2.Bout; obsOV = bus2.OV; obsZ = bus2.Z;
                obsOutValid = bus2.out_valid; obsInReady = bus2.in_ready;
            end
            default: ;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Accepts one operation and waits (bounded) for out_valid; 'noise' pulses in_valid with junk during RUN.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic bin,
                                 input logic noise, output int cycles);
        int guard = 0;
        while (!obsInReady && guard < 50) begin
            tick();
            guard++;
        end
        checkOutput("in_ready_before_accept", 16'(obsInReady), 16'd1);
        tbA       = a;
        tbB       = b;
        tbBinIn   = bin;
        tbInValid = 1'b1;
        tick();
        tbInValid = 1'b0;
        cycles    = 0;
        while (!obsOutValid && cycles < 100) begin
            if (noise) begin
                tbInValid = (cycles % 2 == 0);
                tbA       = 16'hFFFF;
                tbB       = 16'h0000;
                tbBinIn   = 1'b1;
            end
            tick();
            cycles++;
        end
        tbInValid = 1'b0;
        checkOutput("out_valid_seen", 16'(obsOutValid), 16'd1);
    endtask

    task automatic checkResult(input string tag, input logic [15:0] d, input logic bout,
                               input logic ov, input logic z);
        checkOutput({tag, "_D"}, obsD, d);
        checkOutput({tag, "_Bout"}, 16'(obsBout), 16'(bout));
        checkOutput({tag, "_OV"}, 16'(obsOV), 16'(ov));
        checkOutput({tag, "_Z"}, 16'(obsZ), 16'(z));
    endtask

    task automatic completeResult(input string tag);
        tbOutReady = 1'b1;
        tick();
        tbOutReady = 1'b0;
        checkOutput({tag, "_valid_drop"}, 16'(obsOutValid), 16'd0);
        checkOutput({tag, "_idle_ready"}, 16'(obsInReady), 16'd1);
    endtask

    initial begin
        int seen;
        rst        = 1'b1;
        sel        = 2'd0;
        tbA        = '0;
        tbB        = '0;
        tbBinIn    = 1'b0;
        tbInValid  = 1'b0;
        tbOutReady = 1'b0;
        $display("[TB] starting serial_subtractor directed test");

        tick();
        tick();
        checkOutput("reset_in_ready", 16'(obsInReady), 16'd0);
        checkOutput("reset_out_valid", 16'(obsOutValid), 16'd0);
        checkResult("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        checkOutput("post_reset_in_ready", 16'(obsInReady), 16'd1);

        applyStimulus(16'h05, 16'h03, 1'b0, 1'b0, lat);
        checkOutput("lat_8x1", 16'(lat), 16'd8);
        checkResult("05m03", 16'h0002, 1'b0, 1'b0, 1'b0);
        completeResult("05m03");

        applyStimulus(16'h03, 16'h05, 1'b0, 1'b0, lat);
        checkResult("03m05", 16'h00FE, 1'b1, 1'b0, 1'b0);
        completeResult("03m05");

        applyStimulus(16'h80, 16'h01, 1'b0, 1'b0, lat);
        checkResult("80m01", 16'h007F, 1'b0, 1'b1, 1'b0);
        completeResult("80m01");

        applyStimulus(16'h00, 16'h00, 1'b1, 1'b0, lat);
        checkResult("00m00b1", 16'h00FF, 1'b1, 1'b0, 1'b0);
        completeResult("00m00b1");

        applyStimulus(16'h10, 16'h10, 1'b0, 1'b0, lat);
        checkResult("10m10", 16'h0000, 1'b0, 1'b0, 1'b1);
        completeResult("10m10");

        applyStimulus(16'h20, 16'h07, 1'b0, 1'b1, lat);
        checkOutput("lat_noise", 16'(lat), 16'd8);
        checkResult("noise_20m07", 16'h0019, 1'b0, 1'b0, 1'b0);
        completeResult("noise_20m07");

        applyStimulus(16'h7F, 16'hFF, 1'b0, 1'b0, lat);
        checkResult("7Fm FF", 16'h0080, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("hold_valid", 16'(obsOutValid), 16'd1);
            checkOutput("hold_D", obsD, 16'h0080);
        end
        completeResult("7FmFF");

        tbA       = 16'h55;
        tbB       = 16'h11;
        tbBinIn   = 1'b0;
        tbInValid = 1'b1;
        tick();
        tbInValid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        checkOutput("midrun_rst_in_ready", 16'(obsInReady), 16'd0);
        tick();
        rst = 1'b0;
        #1;
        checkOutput("after_rst_in_ready", 16'(obsInReady), 16'd1);
        checkOutput("after_rst_valid", 16'(obsOutValid), 16'd0);
        checkResult("after_rst", 16'h0000, 1'b0, 1'b0, 1'b0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (obsOutValid) seen++;
        end
        checkOutput("abandoned_no_valid", 16'(seen), 16'd0);

        applyStimulus(16'h09, 16'h04, 1'b0, 1'b0, lat);
        checkResult("09m04", 16'h0005, 1'b0, 1'b0, 1'b0);
        completeResult("09m04");

        sel = 2'd1;
        #1;
        applyStimulus(16'hA7, 16'h3C, 1'b0, 1'b0, lat);
        checkOutput("lat_8x4", 16'(lat), 16'd2);
        checkResult("A7m3C", 16'h006B, 1'b0, 1'b1, 1'b0);
        completeResult("A7m3C");

        sel = 2'd2;
        #1;
        applyStimulus(16'h1234, 16'h4321, 1'b0, 1'b0, lat);
        checkOutput("lat_16x2", 16'(lat), 16'd8);
        checkResult("1234m4321", 16'hCF13, 1'b1, 1'b0, 1'b0);
        completeResult("1234m4321");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
